// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS two-port Avalon bus arbiter.
//   bus_state_t : arbiter FSM states (IDLE, I_BUS, D_BUS)
//   bus_src_t   : requester identity used for round-robin history
//   BE_WORD     : full-word byte enable used by instruction fetches
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_BUS,
    D_BUS
  } bus_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } bus_src_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-port-to-one Avalon-MM master: arbitrates the MIPS instruction-fetch
// channel and the data load/store channel onto a single bus master port.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   i_req, i_addr             : fetch request and byte address
//   i_ack, i_rdata            : fetch completion pulse and fetched word
//   d_req, d_we, d_addr,
//   d_wdata, d_be             : data request, store flag, address, data, lanes
//   d_ack, d_rdata            : data completion pulse and load word
//   address, read, write,
//   writedata, byteenable     : Avalon master command (all registered)
//   waitrequest, readdata     : Avalon slave stall and read data
//   busy                      : high while a bus transaction is outstanding
//
// DATA_PRIORITY selects the tie-break winner after reset (1 = data).
module mips_bus_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy
);

  import mips_bus_pkg::*;

  // Seeding history with the non-priority requester makes the priority
  // requester win the first tie.
  localparam bus_src_t RESET_LAST = DATA_PRIORITY ? SRC_I : SRC_D;

  bus_state_t state;
  bus_src_t   last_src;

  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;

  // The word address is formed by clearing [1:0]; the low bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  // A requester whose ack is high this cycle still shows its old request,
  // so it must sit out one arbitration round.
  // NOTE: every output of an always_comb is assigned on every path so that
  // no latch is inferred.
  always_comb begin
    i_elig  = i_req && !i_ack;
    d_elig  = d_req && !d_ack;
    grant_d = d_elig && (!i_elig || (last_src == SRC_I));
    grant_i = i_elig && !grant_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_src   <= RESET_LAST;
      read       <= 1'b0;
      write      <= 1'b0;
      busy       <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= D_BUS;
            busy       <= 1'b1;
            read       <= !d_we;
            write      <= d_we;
            address    <= {d_addr[31:2], 2'b00};
            writedata  <= d_wdata;
            byteenable <= d_be;
          end else if (grant_i) begin
            state      <= I_BUS;
            busy       <= 1'b1;
            read       <= 1'b1;
            write      <= 1'b0;
            address    <= {i_addr[31:2], 2'b00};
            byteenable <= BE_WORD;
          end
        end

        I_BUS, D_BUS: begin
          // Command fields are left untouched until the slave accepts.
          if (!waitrequest) begin
            if (state == I_BUS) begin
              i_rdata  <= readdata;
              i_ack    <= 1'b1;
              last_src <= SRC_I;
            end else begin
              if (read) begin
                d_rdata <= readdata;
              end
              d_ack    <= 1'b1;
              last_src <= SRC_D;
            end
            read  <= 1'b0;
            write <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-port-to-one Avalon memory-mapped master between the MIPS core and the shared memory bus. It takes an instruction-fetch channel and a data load/store channel and arbitrates them onto one Avalon master port. It holds every bus signal stable while `waitrequest` is high and returns read data to the requester with a one-cycle acknowledge. It sits directly upstream of `mips_avalon_slave` (RAM model) in the CPU bus testbenches.

## Interface
- `DATA_PRIORITY`, default 1: tie-break winner after reset and when no history applies (1 = data, 0 = instruction).
- `clk` in 1: single clock. All logic is sampled on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch request. Held high with `i_addr` stable until `i_ack`.
- `i_addr` in 32: fetch byte address.
- `i_ack` out 1: one-cycle pulse when the fetch completes.
- `i_rdata` out 32: fetched word. Valid while `i_ack` is high and held until the next fetch completes.
- `d_req` in 1: data request. Held high with all `d_*` fields stable until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, already lane-aligned.
- `d_be` in 4: byte lanes.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out 32: load word. Valid while `d_ack` is high. Unchanged by stores.
- `address` out 32: Avalon address, with `[1:0]` forced to 0.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `writedata` out 32: Avalon write data.
- `byteenable` out 4: Avalon byte enables.
- `waitrequest` in 1: slave stall.
- `readdata` in 32: slave read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, I_BUS, D_BUS. All outputs are registered.
- IDLE:
  - Sample the eligible requests. A requester whose ack is high in this cycle is ineligible.
  - One eligible: grant it.
  - Both eligible: grant the one not served last. After reset, the `DATA_PRIORITY` winner goes first.
  - On grant, latch the requester's fields into the bus registers and go to I_BUS or D_BUS.
- I_BUS: `read`=1, `write`=0, `byteenable`=4'b1111, `address`={i_addr[31:2],2'b00}.
- D_BUS: `read`=!d_we, `write`=d_we, `byteenable`=d_be, `writedata`=d_wdata, `address`={d_addr[31:2],2'b00}.
- Completion happens on the rising edge where the state is I_BUS or D_BUS and `waitrequest`=0:
  - Capture `readdata` into `i_rdata` or `d_rdata` (loads and fetches only).
  - Drive the matching ack high for the next cycle.
  - Drop `read`/`write` and return to IDLE.
  - Record the last-served requester.
- Bus fields never change while `read` or `write` is high. Requester inputs are not re-sampled during a transaction.
- `read` and `write` are never high together. The bench asserts this every cycle.
- `d_be`=0 on a store is passed through unmodified.

## Timing
- Reset values:
  - `read`, `write`, `i_ack`, `d_ack`, `busy` = 0.
  - `address`, `writedata`, `i_rdata`, `d_rdata` = 0.
  - `byteenable` = 0.
  - State = IDLE. Last-served = the non-priority requester.
- Request sampled at edge E0 → `read`/`write` high after E0.
- If `waitrequest`=0 at E1 → ack high in the cycle after E1. Minimum request-to-ack is 2 cycles. Each stall cycle adds 1.
- After completion there is at least one IDLE cycle (the ack cycle) before the next bus command.
- Back-to-back same-requester throughput: one transaction per 3 cycles at zero wait.
- Simultaneous requests with alternating history produce strict alternation. No starvation.
- Reset during I_BUS or D_BUS:
  - `read`/`write` are low after the reset edge.
  - No ack is issued. The pending request is dropped.
  - Requesters re-request after reset.
- A requester that drops its req before ack is a protocol violation. The arbiter completes the bus transaction anyway and still pulses ack.

## Structure
- Package `mips_bus_pkg` holds:
  - State enum `bus_state_t` (IDLE, I_BUS, D_BUS).
  - Requester enum `bus_src_t` (SRC_I, SRC_D).
  - Constant `BE_WORD` = 4'b1111.
- Single module. No sub-module is needed. The FSM, grant logic and bus registers live in one always block plus the next-state logic.

## Test plan
- Reset: `reset` high for 2 cycles with `i_req`=`d_req`=1 → all outputs 0 throughout. The first bus command appears one cycle after `reset` falls, and it is a data read.
- Fetch with slave READ_DELAY=2 and word 0x24020005 at 0xBFC00000:
  - `read` is high one cycle after `i_req`, with `address`=0xBFC00000 and `byteenable`=1111.
  - `address` is stable across the stall.
  - `i_ack` pulses once with `i_rdata`=0x24020005.
- Store `d_addr`=0x12, `d_wdata`=0xDEADBEEF, `d_be`=0011:
  - `address`=0x10 and `write` is held through `waitrequest`.
  - `d_ack` pulses once.
  - A follow-up load at 0x10 returns 0x0000BEEF on `d_rdata`, and `i_rdata` is unchanged.
- Contention: `i_req` and `d_req` held continuously for 4 transactions → grant order D, I, D, I, with exactly one ack per transaction.
- Zero-wait slave (`waitrequest`=0): `read` is high for exactly one cycle and `i_ack` is high 2 cycles after `i_req` is sampled.
- `reset` asserted while `waitrequest`=1 mid-load → `read`=0 after that edge and no `d_ack` for that request.
